// File: rtl/rvr32_lsa_pkg.sv
// Shared definitions for the N-lane global load/store arbiter:
// FSM state encoding, grant-index width helper and strobe-width helper.
package rvr32_lsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsa_state_t;

    localparam int BYTE_W = 8;

    // Width of an index that can name any of n lanes (never less than 1 bit).
    function automatic int lsa_log2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Number of byte strobes for a data bus of dw bits.
    function automatic int lsa_strb_w(input int dw);
        return dw / BYTE_W;
    endfunction

endpackage

// File: rtl/rvr32_rr_pick.sv
// Combinational NP-wide round-robin picker: returns the first asserted
// request at or above ptr, wrapping from NP-1 back to 0. Expects ptr < NP.
module rvr32_rr_pick
    import rvr32_lsa_pkg::*;
#(
    parameter int NP = 4,
    parameter int IW = lsa_log2(NP)
) (
    input  logic [NP-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic [NP-1:0] grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    localparam logic [IW:0] NP_W = (IW+1)'(NP);

    logic [NP-1:0] rot;
    logic [IW-1:0] first;
    logic [IW:0]   idx_sum;

    // Rotate the request vector so that lane ptr lands at position 0.
    for (genvar gi = 0; gi < NP; gi++) begin : g_rot
        localparam logic [IW:0] OFS = (IW+1)'(gi);
        logic [IW:0]   src_sum;
        logic [IW-1:0] src;
        assign src_sum = OFS + {1'b0, ptr};
        assign src     = (src_sum >= NP_W) ? IW'(src_sum - NP_W) : src_sum[IW-1:0];
        assign rot[gi] = req[src];
    end

    // Lowest set bit of the rotated vector is the winner's distance from ptr.
    always_comb begin
        first = '0;
        for (int i = NP - 1; i >= 0; i--) begin
            if (rot[i]) begin
                first = IW'(i);
            end
        end
    end

    assign any     = |rot;
    assign idx_sum = {1'b0, first} + {1'b0, ptr};
    assign idx     = (idx_sum >= NP_W) ? IW'(idx_sum - NP_W) : idx_sum[IW-1:0];

    for (genvar gi = 0; gi < NP; gi++) begin : g_grant
        assign grant[gi] = any && (idx == IW'(gi));
    end

endmodule

// File: rtl/rvr32_lsa_np.sv
// N-lane global load/store arbiter: round-robin multiplexing of NP lane
// request ports onto one valid/ready memory port, one transaction at a time.
// Optional read coalescing of same-word reads is built when the macro
// RVR32_LSA_COALESCE_EN is defined.
module rvr32_lsa_np
    import rvr32_lsa_pkg::*;
#(
    parameter int NP = 4,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NP*AW-1:0]     addr,
    input  logic [NP*DW-1:0]     wdata,
    input  logic [NP*(DW/8)-1:0] wstrb,
    input  logic [NP-1:0]        valid,
    output logic [NP-1:0]        ready,
    output logic [DW-1:0]        rdata,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    output logic [(DW/8)-1:0]    mem_wstrb,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    input  logic [DW-1:0]        mem_rdata,
    output logic                 busy
);

    localparam int SW = lsa_strb_w(DW);
    localparam int IW = lsa_log2(NP);

    lsa_state_t    state_reg, state_next;
    logic [IW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0] grant_reg, grant_next;
    logic [NP-1:0] mask_reg, mask_next;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
    logic [SW-1:0] mem_wstrb_reg, mem_wstrb_next;
    logic          mem_valid_reg, mem_valid_next;
    logic [DW-1:0] rdata_reg, rdata_next;

    logic [AW-1:0] lane_addr  [NP];
    logic [DW-1:0] lane_wdata [NP];
    logic [SW-1:0] lane_wstrb [NP];

    logic [NP-1:0] pick_grant;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [NP-1:0] idle_mask;

    for (genvar gi = 0; gi < NP; gi++) begin : g_lane
        assign lane_addr[gi]  = addr[gi*AW +: AW];
        assign lane_wdata[gi] = wdata[gi*DW +: DW];
        assign lane_wstrb[gi] = wstrb[gi*SW +: SW];
    end

    rvr32_rr_pick #(
        .NP (NP),
        .IW (IW)
    ) u_pick (
        .req   (valid),
        .ptr   (rr_ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

`ifdef RVR32_LSA_COALESCE_EN
    // Reads from other lanes hitting the same word as the granted read share its response.
    logic [NP-1:0] coal_match;
    for (genvar gi = 0; gi < NP; gi++) begin : g_coal
        assign coal_match[gi] = valid[gi] && (lane_wstrb[gi] == '0) &&
                                (lane_addr[gi][AW-1:2] == lane_addr[pick_idx][AW-1:2]);
    end
    assign idle_mask = (lane_wstrb[pick_idx] == '0) ? (coal_match | pick_grant) : pick_grant;
`else
    assign idle_mask = pick_grant;
`endif

    // Next-state and datapath-load decisions for the IDLE/REQ/RESP sequence.
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_next     = grant_reg;
        mask_next      = mask_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_wstrb_next = mem_wstrb_reg;
        mem_valid_next = mem_valid_reg;
        rdata_next     = rdata_reg;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    mem_addr_next  = lane_addr[pick_idx];
                    mem_wdata_next = lane_wdata[pick_idx];
                    mem_wstrb_next = lane_wstrb[pick_idx];
                    mem_valid_next = 1'b1;
                    grant_next     = pick_idx;
                    mask_next      = idle_mask;
                    state_next     = REQ;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    mem_valid_next = 1'b0;
                    if (mem_wstrb_reg == '0) begin
                        rdata_next = mem_rdata;
                    end
                    state_next = RESP;
                end
            end
            RESP: begin
                // Fairness pointer moves past the granted lane only, even when coalescing.
                rr_ptr_next = (grant_reg == IW'(NP - 1)) ? '0 : grant_reg + IW'(1);
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            grant_reg     <= '0;
            mask_reg      <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
            mem_valid_reg <= 1'b0;
            rdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_reg     <= grant_next;
            mask_reg      <= mask_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_wstrb_reg <= mem_wstrb_next;
            mem_valid_reg <= mem_valid_next;
            rdata_reg     <= rdata_next;
        end
    end

    assign ready     = (state_reg == RESP) ? mask_reg : '0;
    assign busy      = (state_reg != IDLE);
    assign rdata     = rdata_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;
    assign mem_valid = mem_valid_reg;

endmodule

// File: tb/tb_rvr32_lsa_np.sv
// Scoreboard bench for rvr32_lsa_np (NP=4): directed lane requests, a
// simple bus responder, and a monitor that pops expected bus requests and
// lane responses as the DUT presents them.
`timescale 1ns/1ps
module tb_rvr32_lsa_np;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  wdata;
    logic [NP*SW-1:0]  wstrb;
    logic [NP-1:0]     valid;
    logic [NP-1:0]     ready;
    logic [DW-1:0]     rdata;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [SW-1:0]     mem_wstrb;
    logic              mem_valid;
    logic              mem_ready;
    logic [DW-1:0]     mem_rdata;
    logic              busy;

    rvr32_lsa_np #(.NP(NP), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .valid     (valid),
        .ready     (ready),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] a; logic [31:0] d; logic [3:0] s; } req_t;
    typedef struct packed { int dly; logic [31:0] data; } bus_t;
    typedef struct packed { logic [3:0] mask; logic [31:0] rd; } rsp_t;

    req_t lane_q [NP][$];
    req_t exp_bus_q[$];
    bus_t bus_q[$];
    rsp_t exp_rsp_q[$];

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_to   = 0;
    logic expect_idle = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    endtask

    // Lane driver: drops or replaces a lane's request just after its ready pulse.
    initial begin : driver
        logic [NP-1:0] rdy_s;
        req_t r;
        valid = '0; addr = '0; wdata = '0; wstrb = '0;
        forever begin
            @(negedge clk);
            rdy_s = ready;
            @(posedge clk);
            #1;
            if (rst) begin
                valid = '0;
                for (int i = 0; i < NP; i++) lane_q[i].delete();
            end else begin
                for (int i = 0; i < NP; i++) begin
                    if (rdy_s[i]) valid[i] = 1'b0;
                    if (!valid[i] && lane_q[i].size() > 0) begin
                        r = lane_q[i].pop_front();
                        addr[i*AW +: AW]  = r.a;
                        wdata[i*DW +: DW] = r.d;
                        wstrb[i*SW +: SW] = r.s;
                        valid[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Bus responder: answers each new request after its programmed delay.
    initial begin : bus_model
        bus_t b;
        int   cnt;
        logic act;
        mem_ready = 1'b0; mem_rdata = '0; act = 1'b0; cnt = 0; b = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (rst) act = 1'b0;
            else begin
                if (mem_valid && !act && bus_q.size() > 0) begin
                    b = bus_q.pop_front(); cnt = b.dly; act = 1'b1;
                end
                if (act) begin
                    if (cnt == 0) begin
                        mem_ready = 1'b1; mem_rdata = b.data; act = 1'b0;
                    end else cnt--;
                end
            end
        end
    end

    // Monitor: latency rules, bus request contents, lane responses.
    initial begin : monitor
        logic mv_prev = 1'b0, exp_mv = 1'b0, exp_rdy = 1'b0;
        req_t eb;
        rsp_t er;
        int   txn = 0;
        forever begin
            @(negedge clk);
            if (rst || expect_idle) begin
                if (expect_idle) begin
                    chk("idle_ready", 32'(ready), 32'h0);
                    chk("idle_busy", 32'(busy), 32'h0);
                    chk("idle_mem_valid", 32'(mem_valid), 32'h0);
                    chk("idle_rdata", rdata, 32'h0);
                    chk("idle_mem_addr", mem_addr, 32'h0);
                    chk("idle_mem_wstrb", 32'(mem_wstrb), 32'h0);
                end
                exp_mv = 1'b0; exp_rdy = 1'b0;
            end else begin
                if (exp_mv) chk("grant_latency_mem_valid", 32'(mem_valid), 32'h1);
                if (exp_rdy) chk("ready_latency_any", 32'(|ready), 32'h1);
                exp_mv  = !busy && (|valid);
                exp_rdy = mem_valid && mem_ready;
                if (mem_valid && !mv_prev) begin
                    chk("bus_expected", 32'(exp_bus_q.size() > 0), 32'h1);
                    if (exp_bus_q.size() > 0) begin
                        eb = exp_bus_q.pop_front();
                        chk("mem_addr", mem_addr, eb.a);
                        chk("mem_wdata", mem_wdata, eb.d);
                        chk("mem_wstrb", 32'(mem_wstrb), 32'(eb.s));
                    end
                end
                if (|ready) begin
                    chk("rsp_expected", 32'(exp_rsp_q.size() > 0), 32'h1);
                    chk("mem_valid_in_resp", 32'(mem_valid), 32'h0);
                    if (exp_rsp_q.size() > 0) begin
                        er = exp_rsp_q.pop_front();
                        chk("ready_mask", 32'(ready), 32'(er.mask));
                        chk("rdata", rdata, er.rd);
                    end
                    $display("txn %0d: ready=%b rdata=0x%08h", txn, ready, rdata);
                    txn++;
                end
            end
            mv_prev = mem_valid;
        end
    end

    task automatic push_lane(input int l, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_t r;
        r.a = a; r.d = d; r.s = s;
        lane_q[l].push_back(r);
    endtask

    task automatic expect_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input int dly, input logic [31:0] bdata,
                              input logic [3:0] mask, input logic [31:0] rd);
        req_t eb;
        bus_t b;
        rsp_t er;
        eb.a = a; eb.d = d; eb.s = s;
        b.dly = dly; b.data = bdata;
        er.mask = mask; er.rd = rd;
        exp_bus_q.push_back(eb);
        bus_q.push_back(b);
        exp_rsp_q.push_back(er);
    endtask

    task automatic wait_done(input string nm);
        int cyc = 0;
        while ((exp_rsp_q.size() > 0 || exp_bus_q.size() > 0) && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 300) begin
            $display("FAIL %s: timeout with %0d responses outstanding, required 0", nm, exp_rsp_q.size());
            n_to++;
            exp_rsp_q.delete(); exp_bus_q.delete(); bus_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : main
        int cyc;
        rst = 1'b1;
        expect_idle = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        expect_idle = 1'b0;

        // Same-word reads on lanes 0,2; different word on 3; write on 1 (rr_ptr=0).
        push_lane(0, 32'h100, 32'h0, 4'h0);
        push_lane(1, 32'h100, 32'h5A5A5A5A, 4'hF);
        push_lane(2, 32'h102, 32'h0, 4'h0);
        push_lane(3, 32'h104, 32'h0, 4'h0);
`ifdef RVR32_LSA_COALESCE_EN
        expect_txn(32'h100, 32'h0, 4'h0, 1, 32'h11110000, 4'b0101, 32'h11110000);
        expect_txn(32'h100, 32'h5A5A5A5A, 4'hF, 0, 32'hFFFFFFFF, 4'b0010, 32'h11110000);
        expect_txn(32'h104, 32'h0, 4'h0, 1, 32'h33330000, 4'b1000, 32'h33330000);
`else
        expect_txn(32'h100, 32'h0, 4'h0, 1, 32'h11110000, 4'b0001, 32'h11110000);
        expect_txn(32'h100, 32'h5A5A5A5A, 4'hF, 0, 32'hFFFFFFFF, 4'b0010, 32'h11110000);
        expect_txn(32'h102, 32'h0, 4'h0, 0, 32'h22220000, 4'b0100, 32'h22220000);
        expect_txn(32'h104, 32'h0, 4'h0, 1, 32'h33330000, 4'b1000, 32'h33330000);
`endif
        wait_done("coalesce_group");

        // Single lane 2 read, bus answers two cycles after mem_valid.
        push_lane(2, 32'h40, 32'h0, 4'h0);
        expect_txn(32'h40, 32'h0, 4'h0, 2, 32'hDEADBEEF, 4'b0100, 32'hDEADBEEF);
        wait_done("lane2_read");

        // Lane 1 read then partial write; write leaves rdata unchanged.
        push_lane(1, 32'h80, 32'h0, 4'h0);
        push_lane(1, 32'h84, 32'h12345678, 4'b0011);
        expect_txn(32'h80, 32'h0, 4'h0, 1, 32'hAAAA5555, 4'b0010, 32'hAAAA5555);
        expect_txn(32'h84, 32'h12345678, 4'b0011, 0, 32'hFFFFFFFF, 4'b0010, 32'hAAAA5555);
        wait_done("read_then_write");

        // All lanes busy for 8 transactions; rr_ptr is 2 here, so 2,3,0,1,2,3,0,1.
        for (int k = 0; k < 8; k++) begin
            int l;
            l = (2 + k) % NP;
            push_lane(l, 32'h200 + 32'(4 * k), 32'h0, 4'h0);
            expect_txn(32'h200 + 32'(4 * k), 32'h0, 4'h0, k % 3, 32'hC0DE0000 | 32'(k),
                       4'(1 << l), 32'hC0DE0000 | 32'(k));
        end
        wait_done("all_lanes_rotation");

        // Wrap-around: move rr_ptr to 3, then lanes 3 and 0 together -> 3 then 0.
        push_lane(2, 32'h500, 32'h0, 4'h0);
        expect_txn(32'h500, 32'h0, 4'h0, 0, 32'h00000055, 4'b0100, 32'h00000055);
        wait_done("set_ptr_3");
        push_lane(3, 32'h50C, 32'h0, 4'h0);
        push_lane(0, 32'h504, 32'h0, 4'h0);
        expect_txn(32'h50C, 32'h0, 4'h0, 1, 32'h0000D003, 4'b1000, 32'h0000D003);
        expect_txn(32'h504, 32'h0, 4'h0, 0, 32'h0000D000, 4'b0001, 32'h0000D000);
        wait_done("wrap_3_to_0");

        // Reset while lane 1 waits on a slow bus (rr_ptr=1 before reset).
        begin
            req_t eb;
            bus_t b;
            push_lane(1, 32'h300, 32'h0, 4'h0);
            eb.a = 32'h300; eb.d = 32'h0; eb.s = 4'h0;
            exp_bus_q.push_back(eb);
            b.dly = 20; b.data = 32'h0BAD0BAD;
            bus_q.push_back(b);
        end
        cyc = 0;
        while (!mem_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!mem_valid) begin
            $display("FAIL reset_setup: mem_valid got 0, required 1 within 50 cycles");
            n_to++;
        end
        @(posedge clk);
        #2;
        expect_idle = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        expect_idle = 1'b0;
        exp_bus_q.delete();
        bus_q.delete();

        // After reset rr_ptr is 0, so lane 0 wins over lane 3.
        push_lane(3, 32'h40C, 32'h0, 4'h0);
        push_lane(0, 32'h400, 32'h0, 4'h0);
        expect_txn(32'h400, 32'h0, 4'h0, 0, 32'h00000A00, 4'b0001, 32'h00000A00);
        expect_txn(32'h40C, 32'h0, 4'h0, 1, 32'h0000D00D, 4'b1000, 32'h0000D00D);
        wait_done("post_reset_grant");

        $display("%0d/%0d checks passed", n_pass, n_chk + n_to);
        $finish;
    end

endmodule

// File: doc/rvr32_lsa_np.md
Name: rvr32_lsa_np

Overview:
- N-lane successor to the fixed 4-lane global load/store arbiter.
- Multiplexes NP scalar-processor memory ports onto one global memory port using a valid/ready (hold-until-ready) handshake.
- Round-robin grant; registered read data is broadcast to all lanes.
- Sits in the compute unit between the per-lane global request path (address bit 31 = 0) and the system bus.

Parameters:
- NP, 4, number of lanes (2..16).
- AW, 32, address width.
- DW, 32, data width; strobe width is DW/8.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr  in  NP*AW  lane addresses; lane i occupies [i*AW +: AW].
- wdata  in  NP*DW  lane write data.
- wstrb  in  NP*(DW/8)  lane byte strobes; all-zero means read.
- valid  in  NP  lane request, held until that lane's ready.
- ready  out  NP  one-cycle completion pulse per lane.
- rdata  out  DW  registered read data, shared by all lanes.
- mem_addr  out  AW  bus address.
- mem_wdata  out  DW  bus write data.
- mem_wstrb  out  DW/8  bus strobes.
- mem_valid  out  1  bus request.
- mem_ready  in  1  bus completion, same-cycle mem_rdata valid.
- mem_rdata  in  DW  bus read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: ready=0, rdata=0, mem_valid=0, mem_addr/wdata/wstrb=0, busy=0, state=IDLE, rr_ptr=0.
- FSM IDLE:
  - If any valid is high, pick the first high lane searching upward from rr_ptr with wrap (NP-1 -> 0).
  - Register that lane's addr/wdata/wstrb into mem_*, assert mem_valid, store grant index g, go to REQ.
  - Otherwise stay in IDLE.
- FSM REQ:
  - Hold mem_* stable.
  - On mem_ready: deassert mem_valid, capture mem_rdata into rdata if the request was a read, go to RESP.
- FSM RESP:
  - ready[g]=1 for exactly this cycle.
  - rr_ptr <= (g+1) mod NP, go to IDLE.
- Latency:
  - Request seen in cycle 0 gives mem_valid in cycle 1.
  - mem_ready in cycle k gives ready[g] in cycle k+1.
  - Minimum 3 cycles per transaction; no back-to-back overlap.
- Writes: rdata is unchanged.
- Lane rule: a lane drops valid, or presents a new request, on the edge after its ready.
  - IDLE samples valid one cycle after RESP, so a released lane is never regranted spuriously.
- Lane valid dropped while granted (protocol violation): bus transaction still completes; ready[g] still pulses; no other effect.
- Simultaneous requests: exactly one grant per transaction. With all NP lanes valid continuously, grants rotate 0,1,..,NP-1,0.
- mem_ready while not in REQ: ignored.
- Reset mid-transaction: all outputs return to reset values immediately; the in-flight request is abandoned.

Optional Feature:
- Macro: RVR32_LSA_COALESCE_EN.
- Enabled:
  - On the IDLE->REQ transition of a read, a coalesce mask is registered.
  - The mask holds every lane with valid=1, wstrb=0, and addr[AW-1:2] equal to the granted lane's addr[AW-1:2].
  - In RESP, ready pulses for all lanes in the mask, sharing one rdata.
  - rr_ptr advances past g only.
  - Writes never coalesce.
- Disabled: the mask is the one-hot of g only; the logic is absent from the netlist.

Decomposition:
- Package rvr32_lsa_pkg: state encoding (IDLE=2'd0, REQ=2'd1, RESP=2'd2), log2 helper for the grant-index width, strobe-width constant.
- Sub-module rvr32_rr_pick: combinational NP-wide round-robin priority picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, index, any.
  - Reused by a later N-lane PC aggregator.

Test Plan:
- NP=4, single lane 2 reads 0x0000_0040; bus mem_ready after 2 cycles with rdata 0xDEADBEEF -> mem_valid in cycle 1, ready=4'b0100 one cycle after mem_ready, rdata=0xDEADBEEF.
- All 4 lanes hold valid for 8 transactions -> grant order 0,1,2,3,0,1,2,3; mem_valid never high during RESP.
- Lane 1 writes wstrb=4'b0011, wdata=0x1234_5678 after a read returned 0xAAAA_5555 -> mem_wstrb=4'b0011, mem_wdata=0x12345678, rdata stays 0xAAAA5555.
- Assert rst during REQ with mem_valid=1 -> mem_valid, busy, ready all 0 in the same cycle; the next request is granted from lane 0.
- COALESCE_EN: lanes 0, 2, 3 read 0x100, 0x102, 0x104; lane 1 writes 0x100 -> ready=4'b0101 with shared rdata, then lane 1, then lane 3.
- NP=8 build: lanes 7 and 0 valid with rr_ptr=7 -> lane 7 granted first, then lane 0 (wrap-around).
